// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared encodings and register-match helper for hazard_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // $0 is hardwired to zero, so it can never carry a real dependency
   function automatic logic regmatch(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_stall_fsm.sv
// ============================================================================
// div_stall_fsm : counter FSM holding E while the multi-cycle divider runs
// Rev 1.0
// ============================================================================
`default_nettype none

module div_stall_fsm
   import hazard_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic divstartE,
   output logic divstall,
   output logic div_doneE
);

   div_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DIV_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      divstall  = 1'b0;
      div_doneE = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (divstartE) begin
               state_nxt = DIV_BUSY;
               cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
            end
         end
         DIV_BUSY: begin
            divstall = 1'b1;
            if (cnt == '0) state_nxt = DIV_DONE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         DIV_DONE: begin
            // a start seen here belongs to the finishing div, not a new one
            div_doneE = 1'b1;
            state_nxt = DIV_IDLE;
         end
         default: state_nxt = DIV_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit : stall/flush/forward generation for the 5-stage pipeline.
// Optional macro BRANCH_FWD_EN enables M->D forwarding for branch compares.
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_unit
   import hazard_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic       branchD,
   input  logic       jrD,
   input  logic       jalrD,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] writeregE,
   input  logic       regwriteE,
   input  logic       memtoregE,
   input  logic       divstartE,
   input  logic [4:0] writeregM,
   input  logic       regwriteM,
   input  logic       memtoregM,
   input  logic [4:0] writeregW,
   input  logic       regwriteW,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       flushE,
   output logic       flushM,
   output logic       forwardaD,
   output logic       forwardbD,
   output logic [1:0] forwardaE,
   output logic [1:0] forwardbE,
   output logic       div_doneE
);

   logic divstall, div_done_raw;
   logic lwstall, brstall;
   logic hit_rs, hit_rt;
   logic fwd_aD, fwd_bD;
   logic [1:0] fwd_aE, fwd_bE;

   div_stall_fsm #(
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_div_fsm (
      .clk       (clk),
      .rst       (rst),
      .divstartE (divstartE),
      .divstall  (divstall),
      .div_doneE (div_done_raw)
   );

   always_comb begin
      fwd_aE = FWD_NONE;
      fwd_bE = FWD_NONE;
      if (regwriteM && regmatch(writeregM, rsE))      fwd_aE = FWD_MEM;
      else if (regwriteW && regmatch(writeregW, rsE)) fwd_aE = FWD_WB;
      if (regwriteM && regmatch(writeregM, rtE))      fwd_bE = FWD_MEM;
      else if (regwriteW && regmatch(writeregW, rtE)) fwd_bE = FWD_WB;
   end

   assign lwstall = memtoregE && regwriteE &&
                    (regmatch(writeregE, rsD) || regmatch(writeregE, rtD));

`ifdef BRANCH_FWD_EN
   assign hit_rs = (regwriteE && regmatch(writeregE, rsD)) ||
                   (memtoregM && regmatch(writeregM, rsD));
   assign hit_rt = (regwriteE && regmatch(writeregE, rtD)) ||
                   (memtoregM && regmatch(writeregM, rtD));
   assign fwd_aD = regwriteM && !memtoregM && regmatch(writeregM, rsD);
   assign fwd_bD = regwriteM && !memtoregM && regmatch(writeregM, rtD);
`else
   // without the D-stage bypass, any pending M write must also drain first
   assign hit_rs = (regwriteE && regmatch(writeregE, rsD)) ||
                   (memtoregM && regmatch(writeregM, rsD)) ||
                   (regwriteM && regmatch(writeregM, rsD));
   assign hit_rt = (regwriteE && regmatch(writeregE, rtD)) ||
                   (memtoregM && regmatch(writeregM, rtD)) ||
                   (regwriteM && regmatch(writeregM, rtD));
   assign fwd_aD = 1'b0;
   assign fwd_bD = 1'b0;
`endif

   // register jumps read rs only
   assign brstall = (branchD && (hit_rs || hit_rt)) || ((jrD || jalrD) && hit_rs);

   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      flushE    = 1'b0;
      flushM    = 1'b0;
      forwardaD = 1'b0;
      forwardbD = 1'b0;
      forwardaE = FWD_NONE;
      forwardbE = FWD_NONE;
      div_doneE = 1'b0;
      if (!rst) begin
         stallF    = lwstall || brstall || divstall;
         stallD    = lwstall || brstall || divstall;
         stallE    = divstall;
         flushM    = divstall;
         flushE    = (lwstall || brstall) && !divstall;
         forwardaD = fwd_aD;
         forwardbD = fwd_bD;
         forwardaE = fwd_aE;
         forwardbE = fwd_bE;
         div_doneE = div_done_raw;
      end
   end

endmodule

`default_nettype wire
